// File: rtl/rr_dest_scheduler_pkg.sv
// Shared definitions for the round-robin destination scheduler.
// Build option: define RR_STATS_EN to enable the per-output push counters.
package rr_sched_pkg;

  localparam int unsigned N_PORTS = 4;
  localparam int unsigned DEST_HI = 9;
  localparam int unsigned DEST_LO = 8;
  localparam int unsigned MAX_W   = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Destination is the top two bits of a word of the given width (width <= MAX_W).
  function automatic logic [1:0] dest_of(input logic [MAX_W-1:0] word,
                                         input int unsigned      width);
    return word[width-1 -: 2];
  endfunction

endpackage

// File: rtl/rr_dest_scheduler_next_grant.sv
// Rotating-priority finder: first eligible index at or after start, wrapping mod 4.
module rr_next_grant
  import rr_sched_pkg::*;
(
  input  logic [N_PORTS-1:0] eligible,
  input  logic [1:0]         start,
  output logic               found,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      cand = start + 2'(k);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_dest_scheduler.sv
// Round-robin scheduler moving one word per cycle from 4 input FIFOs to 4 output FIFOs.
// Build option: RR_STATS_EN adds per-output push counters on push_cnt (tied to 0 otherwise).
module rr_dest_scheduler
  import rr_sched_pkg::*;
#(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned BURST_MAX = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_PORTS-1:0]         empty_in,
  input  logic [N_PORTS*DATA_W-1:0]  data_in,
  output logic [N_PORTS-1:0]         pop_in,
  input  logic [N_PORTS-1:0]         almost_full_out,
  output logic [N_PORTS-1:0]         push_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [1:0]                 grant_idx,
  output logic                       busy,
  output logic [N_PORTS*CNT_W-1:0]   push_cnt
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  state_e             state_q, state_d;
  logic [N_PORTS-1:0] push_q, push_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [1:0]         gidx_q, gidx_d;
  logic [3:0]         burst_q, burst_d;

  logic [1:0]         dest [N_PORTS];
  logic [N_PORTS-1:0] elig;
  logic [1:0]         search_start;
  logic [1:0]         search_idx;
  logic               search_found;
  logic               keep;
  logic               grant;
  logic [1:0]         gsel;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      dest[i] = dest_of(MAX_W'(data_in[i*DATA_W +: DATA_W]), DATA_W);
      elig[i] = !empty_in[i] && !almost_full_out[dest[i]];
    end
  end

  assign search_start = gidx_q + 2'd1;

  rr_next_grant u_next_grant (
    .eligible (elig),
    .start    (search_start),
    .found    (search_found),
    .idx      (search_idx)
  );

  // burst_q==0 means nothing granted since reset, so the reset pointer value is not a burst owner.
  assign keep = elig[gidx_q] && (burst_q != 4'd0) && (burst_q < BURST_LIM);

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    gsel    = search_idx;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && |(~empty_in)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable || &empty_in) begin
          state_d = ST_IDLE;
        end else if (keep) begin
          grant = 1'b1;
          gsel  = gidx_q;
        end else if (search_found) begin
          grant = 1'b1;
          gsel  = search_idx;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push_d  = '0;
    data_d  = data_q;
    gidx_d  = gidx_q;
    burst_d = burst_q;
    if (grant) begin
      push_d = N_PORTS'(1) << dest[gsel];
      data_d = data_in[gsel*DATA_W +: DATA_W];
      gidx_d = gsel;
      if (gsel == gidx_q && burst_q != 4'd0)
        burst_d = (burst_q < BURST_LIM) ? burst_q + 4'd1 : burst_q;
      else
        burst_d = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      push_q  <= '0;
      data_q  <= '0;
      gidx_q  <= 2'd3;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      data_q  <= data_d;
      gidx_q  <= gidx_d;
      burst_q <= burst_d;
    end
  end

  assign pop_in    = (grant && reset) ? (N_PORTS'(1) << gsel) : '0;
  assign push_out  = push_q;
  assign data_out  = data_q;
  assign grant_idx = gidx_q;
  assign busy      = (state_q == ST_RUN);

`ifdef RR_STATS_EN
  logic [N_PORTS*CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      if (push_q[j]) cnt_d[j*CNT_W +: CNT_W] = cnt_q[j*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign push_cnt = cnt_q;
`else
  assign push_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_dest_scheduler.sv
// Self-checking bench for rr_dest_scheduler: vector tables plus scoreboard of expected pushes.
module tb_rr_dest_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  empty_in;
  logic [39:0] data_in;
  logic [3:0]  af;

  logic [3:0]  pop1, pop2, push1, push2;
  logic [9:0]  dout1, dout2;
  logic [1:0]  g1, g2;
  logic        busy1, busy2;
  logic [63:0] cnt1, cnt2;

  always #5 clk = ~clk;

  rr_dest_scheduler #(.DATA_W(10), .BURST_MAX(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .empty_in(empty_in), .data_in(data_in),
    .pop_in(pop1), .almost_full_out(af), .push_out(push1), .data_out(dout1),
    .grant_idx(g1), .busy(busy1), .push_cnt(cnt1));

  rr_dest_scheduler #(.DATA_W(10), .BURST_MAX(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .empty_in(empty_in), .data_in(data_in),
    .pop_in(pop2), .almost_full_out(af), .push_out(push2), .data_out(dout2),
    .grant_idx(g2), .busy(busy2), .push_cnt(cnt2));

  bit sel = 1'b0;
  logic [3:0] obs_pop, obs_push;
  logic [9:0] obs_dout;
  logic [1:0] obs_g;
  logic       obs_busy;
  assign obs_pop  = sel ? pop2  : pop1;
  assign obs_push = sel ? push2 : push1;
  assign obs_dout = sel ? dout2 : dout1;
  assign obs_g    = sel ? g2    : g1;
  assign obs_busy = sel ? busy2 : busy1;

  typedef struct packed {
    logic        en;
    logic [3:0]  empty;
    logic [39:0] words;
    logic [3:0]  af;
    logic [3:0]  exp_pop;
  } vec_t;

  typedef struct packed {
    logic [3:0] push;
    logic [9:0] data;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  string tag = "";

  function automatic vec_t mk(input logic en, input logic [3:0] empty,
                              input logic [9:0] w0, w1, w2, w3,
                              input logic [3:0] a, input logic [3:0] ep);
    vec_t v;
    v.en = en; v.empty = empty; v.words = {w3, w2, w1, w0}; v.af = a; v.exp_pop = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %0h, want %0h", tag, name, act, exp);
    end
  endtask

  task automatic drive_pop(input vec_t v);
    exp_t e;
    logic [9:0] w;
    enable = v.en; empty_in = v.empty; data_in = v.words; af = v.af;
    #1;
    chk("pop_in", 32'(obs_pop), 32'(v.exp_pop));
    e = '0;
    for (int i = 0; i < 4; i++) begin
      if (v.exp_pop[i]) begin
        w = v.words[i*10 +: 10];
        e.push = 4'b0001 << w[9:8];
        e.data = w;
      end
    end
    sb.push_back(e);
  endtask

  task automatic edge_push();
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s scoreboard: got empty queue, want an entry", tag);
    end else begin
      e = sb.pop_front();
      chk("push_out", 32'(obs_push), 32'(e.push));
      if (e.push != 4'b0000) chk("data_out", 32'(obs_dout), 32'(e.data));
    end
  endtask

  task automatic run_tbl();
    for (int unsigned k = 0; k < tbl.size(); k++) begin
      drive_pop(tbl[k]);
      edge_push();
    end
    tbl.delete();
  endtask

  task automatic do_reset(input int unsigned cycles);
    reset = 1'b0;
    sb.delete();
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    // T1: reset held with live stimulus
    tag = "T1";
    reset = 1'b0; enable = 1'b1; empty_in = 4'b0000; af = 4'b0000;
    data_in = {10'h344, 10'h233, 10'h122, 10'h011};
    repeat (3) @(posedge clk);
    #1;
    chk("pop_in",    32'(obs_pop),  32'h0);
    chk("push_out",  32'(obs_push), 32'h0);
    chk("data_out",  32'(obs_dout), 32'h0);
    chk("grant_idx", 32'(obs_g),    32'h3);
    chk("busy",      32'(obs_busy), 32'h0);
    reset = 1'b1;

    // T2: full rotation, BURST_MAX=1
    tag = "T2";
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0010));
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0100));
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b1000));
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0001));
    run_tbl();
    chk("busy", 32'(obs_busy), 32'h1);

    // T3: blocked destination skipped, then released; idle and pointer hold
    tag = "T3";
    tbl.push_back(mk(1, 4'b1100, 10'h201, 10'h055, 10'h000, 10'h000, 4'b0100, 4'b0010));
    tbl.push_back(mk(1, 4'b1110, 10'h201, 10'h055, 10'h000, 10'h000, 4'b0100, 4'b0000));
    tbl.push_back(mk(1, 4'b1110, 10'h201, 10'h055, 10'h000, 10'h000, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 4'b1111, 10'h201, 10'h055, 10'h000, 10'h000, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0010));
    tbl.push_back(mk(0, 4'b1111, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0000));
    run_tbl();
    chk("data_out_hold", 32'(obs_dout), 32'h122);
    chk("busy_idle",     32'(obs_busy), 32'h0);

    // T4: BURST_MAX=2 on the second instance
    tag = "T4";
    sel = 1'b1;
    do_reset(2);
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0010));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0010));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0100));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0100));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b1000));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b1000));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0010));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0010, 4'b0100));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b0100));
    tbl.push_back(mk(1, 4'b0000, 10'h0A1, 10'h1B2, 10'h2C3, 10'h3D4, 4'b0000, 4'b1000));
    run_tbl();

    // T5: reset asserted while a word is registered
    tag = "T5";
    sel = 1'b0;
    do_reset(2);
    drive_pop(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0000));
    edge_push();
    drive_pop(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0001));
    edge_push();
    drive_pop(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0010));
    edge_push();
    reset = 1'b0;
    #1;
    chk("push_out_async", 32'(obs_push), 32'h0);
    chk("pop_in_rst",     32'(obs_pop),  32'h0);
    chk("grant_idx_rst",  32'(obs_g),    32'h3);
    chk("data_out_rst",   32'(obs_dout), 32'h0);
    @(posedge clk); #1;
    chk("push_out_held",  32'(obs_push), 32'h0);
    reset = 1'b1;
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 10'h011, 10'h122, 10'h233, 10'h344, 4'b0000, 4'b0001));
    run_tbl();

    // T6: push counters
    tag = "T6";
`ifdef RR_STATS_EN
    do_reset(2);
    enable = 1'b1; empty_in = 4'b0000; af = 4'b0000;
    data_in = {10'h144, 10'h133, 10'h122, 10'h111};
    repeat (70001) @(posedge clk);
    #1 empty_in = 4'b1111;
    @(posedge clk); #1;
    chk("cnt0", 32'(cnt1[15:0]),  32'h0);
    chk("cnt1", 32'(cnt1[31:16]), 32'd4464);
    chk("cnt2", 32'(cnt1[47:32]), 32'h0);
    chk("cnt3", 32'(cnt1[63:48]), 32'h0);
`else
    chk("cnt_lo", cnt1[31:0],  32'h0);
    chk("cnt_hi", cnt1[63:32], 32'h0);
    chk("cnt2",   cnt2[31:0],  32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
